// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage and the external data memory.
//   mem_req   : access request, held until mem_ack
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_be    : byte-lane enables, bit i = lane i (little-endian)
//   mem_wdata : store data
//   mem_ack   : memory completes the access this cycle
//   mem_rdata : load data, valid with mem_ack
// master = memory stage, slave = memory.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory stage. Takes the execute-stage bundle, passes ALU results
// straight to write-back, and runs word/byte loads and stores over a
// req/ack handshake, stalling IF/ID/EX while an access is outstanding.
//   clk, rst        : clock, async active-high reset
//   ex_valid ..     : execute-stage bundle (address/result, store data,
//                     destination, MemWrite/memtoreg/regWrite/is_byte)
//   stall           : freeze upstream stages (high in every ACCESS cycle)
//   mem             : data-memory bus (master side)
//   wb_*            : registered write-back bundle, one cycle per retire
//   align_err       : one-cycle pulse after accepting a misaligned word op
//
// state  | meaning
// IDLE   | sampling the execute bundle every cycle
// ACCESS | memory request outstanding, waiting for mem_ack
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] operand_2_out,
  input  logic [4:0]        destReg_out,
  input  logic              MemWrite_out,
  input  logic              memtoreg_out,
  input  logic              regWrite_out,
  input  logic              is_byte_out,
  output logic              stall,
  mem_access_stage_if.master mem,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [4:0]        wb_destReg,
  output logic [ADDR_W-1:0] wb_data,
  output logic              align_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              mem_op;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              store_q;
  logic              byte_q;
  logic              regwrite_q;
  logic [4:0]        dest_q;
  logic [7:0]        load_byte;
  logic [ADDR_W-1:0] load_data;

  // Store wins when both MemWrite and memtoreg are set.
  assign mem_op = ex_valid & (MemWrite_out | memtoreg_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Bus outputs are zero outside ACCESS so a reset drops the request at once.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = 4'h0;
    mem.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (mem_op) state_d = ACCESS;
      end
      ACCESS: begin
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = store_q;
        mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem.mem_be    = be_q;
        mem.mem_wdata = wdata_q;
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: load_byte = mem.mem_rdata[7:0];
      2'd1: load_byte = mem.mem_rdata[15:8];
      2'd2: load_byte = mem.mem_rdata[23:16];
      2'd3: load_byte = mem.mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_data = byte_q ? {{(ADDR_W-8){load_byte[7]}}, load_byte} : mem.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'h0;
      store_q     <= 1'b0;
      byte_q      <= 1'b0;
      regwrite_q  <= 1'b0;
      dest_q      <= 5'd0;
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_destReg  <= 5'd0;
      wb_data     <= '0;
      align_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      if (state_q == IDLE) begin
        wb_valid    <= ex_valid & ~mem_op;
        wb_regWrite <= ex_valid & regWrite_out & ~mem_op;
        wb_destReg  <= destReg_out;
        wb_data     <= alu_out;
        if (mem_op) begin
          addr_q     <= alu_out;
          store_q    <= MemWrite_out;
          byte_q     <= is_byte_out;
          regwrite_q <= regWrite_out;
          dest_q     <= destReg_out;
          be_q       <= is_byte_out ? (4'b0001 << alu_out[1:0]) : 4'hF;
          // Loads drive zero write data; byte stores replicate the byte on all lanes.
          if (!MemWrite_out)    wdata_q <= '0;
          else if (is_byte_out) wdata_q <= {4{operand_2_out[7:0]}};
          else                  wdata_q <= operand_2_out;
          align_err  <= ~is_byte_out & (alu_out[1:0] != 2'b00);
        end
      end else begin
        wb_valid    <= mem.mem_ack;
        wb_regWrite <= mem.mem_ack & ~store_q & regwrite_q;
        wb_destReg  <= dest_q;
        wb_data     <= store_q ? addr_q : load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_out;
  logic [31:0] operand_2_out;
  logic [4:0]  destReg_out;
  logic        MemWrite_out, memtoreg_out, regWrite_out, is_byte_out;
  logic        stall;
  logic        wb_valid, wb_regWrite;
  logic [4:0]  wb_destReg;
  logic [31:0] wb_data;
  logic        align_err;

  mem_access_stage_if bus ();

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_out(alu_out),
    .operand_2_out(operand_2_out), .destReg_out(destReg_out),
    .MemWrite_out(MemWrite_out), .memtoreg_out(memtoreg_out),
    .regWrite_out(regWrite_out), .is_byte_out(is_byte_out),
    .stall(stall), .mem(bus), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_destReg(wb_destReg), .wb_data(wb_data), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  d;
    logic [31:0] data;
    bit          chk_data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_be;
  } req_exp_t;

  wb_exp_t     wb_q[$];
  req_exp_t    req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_align = 0;
  int          seen_align = 0;
  int          force_lat = 0;
  bit          junk_en = 1'b0;
  bit          junk_all = 1'b0;
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] phys_mem[int unsigned];

  function automatic logic [31:0] init_word(int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] phys_rd(int unsigned w);
    return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bundle, record its expected effects, hold it until accepted.
  task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] op2,
                       input logic [4:0] d, input logic mw, input logic mtr,
                       input logic rw, input logic bt);
    wb_exp_t     e;
    req_exp_t    r;
    logic [31:0] w;
    logic [7:0]  b;
    int unsigned wa;
    int          lane;
    bit          acc;
    int          n;
    ex_valid = v; alu_out = a; operand_2_out = op2; destReg_out = d;
    MemWrite_out = mw; memtoreg_out = mtr; regWrite_out = rw; is_byte_out = bt;
    wa   = a >> 2;
    lane = int'(a[1:0]);
    if (v && (mw || mtr)) begin
      if (!bt && a[1:0] != 2'b00) exp_align++;
      r.addr = a & 32'hFFFF_FFFC;
      if (mw) begin
        r.we = 1'b1; r.chk_be = 1'b1;
        if (bt) begin
          r.be    = 4'(1 << lane);
          r.wdata = {4{op2[7:0]}};
          w = ref_rd(wa);
          w[8*lane +: 8] = op2[7:0];
        end else begin
          r.be = 4'hF; r.wdata = op2; w = op2;
        end
        ref_mem[wa] = w;
        e.rw = 1'b0; e.d = d; e.data = 32'h0; e.chk_data = 1'b0;
      end else begin
        r.we = 1'b0; r.wdata = 32'h0; r.be = 4'hF; r.chk_be = !bt;
        w = ref_rd(wa);
        b = 8'(w >> (8 * lane));
        e.rw = rw; e.d = d; e.chk_data = 1'b1;
        if (!bt)            e.data = w;
        else if (b >= 8'h80) e.data = 32'hFFFF_FF00 | {24'h0, b};
        else                 e.data = {24'h0, b};
      end
      req_q.push_back(r);
      wb_q.push_back(e);
    end else if (v) begin
      e.rw = rw; e.d = d; e.data = a; e.chk_data = 1'b1;
      wb_q.push_back(e);
    end
    n = 0;
    do begin
      acc = !stall;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_accept actual=stalled required=accepted at %0t", $time);
    end
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=stall required=idle at %0t", $time);
    end
  endtask

  // Write-back monitor / scoreboard.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (align_err) seen_align++;
        if (stall) chk("wb_valid_in_access", {31'h0, wb_valid}, 32'h0);
        if (wb_valid) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected actual=valid required=none data=%h at %0t", wb_data, $time);
          end else begin
            e = wb_q.pop_front();
            chk("wb_regWrite", {31'h0, wb_regWrite}, {31'h0, e.rw});
            if (e.chk_data) begin
              chk("wb_destReg", {27'h0, wb_destReg}, {27'h0, e.d});
              chk("wb_data", wb_data, e.data);
            end
          end
        end
      end
    end
  end

  // Memory responder: checks each request against the model and acks after a latency.
  initial begin
    int          k;
    int          lat;
    bit          prev;
    logic [31:0] w, st_addr, st_wdata;
    logic [3:0]  st_be;
    logic        st_we;
    req_exp_t    r;
    k = 0; lat = 1; prev = 1'b0;
    st_addr = 0; st_wdata = 0; st_be = 0; st_we = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (!prev) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected actual=req addr=%h required=none at %0t", bus.mem_addr, $time);
          end else begin
            r = req_q.pop_front();
            chk("req_we", {31'h0, bus.mem_we}, {31'h0, r.we});
            chk("req_addr", bus.mem_addr, r.addr);
            chk("req_wdata", bus.mem_wdata, r.wdata);
            if (r.chk_be) chk("req_be", {28'h0, bus.mem_be}, {28'h0, r.be});
          end
          st_addr = bus.mem_addr; st_wdata = bus.mem_wdata;
          st_be = bus.mem_be; st_we = bus.mem_we;
          lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
          k = 0;
        end else begin
          chk("req_hold_addr", bus.mem_addr, st_addr);
          chk("req_hold_wdata", bus.mem_wdata, st_wdata);
          chk("req_hold_be", {28'h0, bus.mem_be}, {28'h0, st_be});
          chk("req_hold_we", {31'h0, bus.mem_we}, {31'h0, st_we});
        end
        k++;
        if (k == lat) begin
          w = phys_rd(bus.mem_addr >> 2);
          bus.mem_rdata = w;
          if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            phys_mem[bus.mem_addr >> 2] = w;
          end
          bus.mem_ack = 1'b1;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
        bus.mem_ack = junk_all || (junk_en && ($urandom_range(0, 1) == 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n, lo, ae;
    int unsigned kind, a;
    rst = 1'b1;
    ex_valid = 0; alu_out = 0; operand_2_out = 0; destReg_out = 0;
    MemWrite_out = 0; memtoreg_out = 0; regWrite_out = 0; is_byte_out = 0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_align_err", {31'h0, align_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of an access.
    force_lat = 10;
    issue(1, 32'h0000_0080, 32'h0, 5'd3, 0, 1, 1, 0);
    @(negedge clk);
    chk("mid_mem_req_before", {31'h0, bus.mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    wb_q.delete();
    req_q.delete();
    @(negedge clk);
    rst = 1'b0;
    junk_all = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_stall", {31'h0, stall}, 32'h0);
      chk("post_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      chk("post_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    end
    junk_all = 1'b0;
    force_lat = 0;

    // ALU pass-through.
    issue(1, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 1, 0);
    chk("alu_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("alu_wb_dest", {27'h0, wb_destReg}, 32'd5);
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    chk("alu_stall", {31'h0, stall}, 32'h0);

    // Word load, ack on the third ACCESS cycle.
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    phys_mem[32'h40] = 32'hDEAD_BEEF;
    force_lat = 3;
    issue(1, 32'h0000_0100, 32'h0, 5'd7, 0, 1, 1, 0);
    n = 0;
    while (bus.mem_req && n < 20) begin
      chk("lw_addr", bus.mem_addr, 32'h0000_0100);
      chk("lw_be", {28'h0, bus.mem_be}, 32'hF);
      chk("lw_stall", {31'h0, stall}, 32'h1);
      n++;
      @(negedge clk);
    end
    chk("lw_req_cycles", n, 3);
    chk("lw_stall_after", {31'h0, stall}, 32'h0);
    chk("lw_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("lw_wb_regWrite", {31'h0, wb_regWrite}, 32'h1);
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);

    // Byte loads with sign extension, ack in the first cycle.
    ref_mem[32'h40] = 32'h80FF_0000;
    phys_mem[32'h40] = 32'h80FF_0000;
    force_lat = 1;
    issue(1, 32'h0000_0103, 32'h0, 5'd8, 0, 1, 1, 1);
    chk("lb3_addr", bus.mem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("lb3_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("lb3_wb_data", wb_data, 32'hFFFF_FF80);
    issue(1, 32'h0000_0101, 32'h0, 5'd8, 0, 1, 1, 1);
    chk("lb1_addr", bus.mem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("lb1_wb_data", wb_data, 32'h0000_0000);

    // Byte store.
    issue(1, 32'h0000_0202, 32'h1234_56AB, 5'd2, 1, 0, 1, 1);
    chk("sb_we", {31'h0, bus.mem_we}, 32'h1);
    chk("sb_be", {28'h0, bus.mem_be}, 32'h4);
    chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", bus.mem_addr, 32'h0000_0200);
    wait_idle();
    chk("sb_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("sb_wb_regWrite", {31'h0, wb_regWrite}, 32'h0);

    // Misaligned word store followed by a held load.
    force_lat = 2;
    issue(1, 32'h0000_0305, 32'hCAFE_0001, 5'd0, 1, 0, 0, 0);
    chk("misal_align_err", {31'h0, align_err}, 32'h1);
    chk("misal_addr", bus.mem_addr, 32'h0000_0304);
    ae = 1; lo = 0; n = 0;
    fork
      issue(1, 32'h0000_0304, 32'h0, 5'd9, 0, 1, 1, 0);
      begin
        @(negedge clk);
        while (bus.mem_req && n < 10) begin
          if (align_err) ae++;
          n++;
          @(negedge clk);
        end
        while (!bus.mem_req && lo < 10) begin
          if (align_err) ae++;
          lo++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_req_gap", lo, 1);
    chk("misal_pulse_count", ae, 1);
    wait_idle();
    force_lat = 0;

    // Randomized mix with random latencies and spurious idle acks.
    junk_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 7);
      a = 32'h0000_0400 + $urandom_range(0, 63);
      if ((kind == 3 || kind == 5) && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      case (kind)
        0: issue(0, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        1, 2: issue(1, $urandom, $urandom, 5'($urandom), 0, 0, 1'($urandom), 1'($urandom));
        3: issue(1, a, $urandom, 5'($urandom), 0, 1, 1'($urandom), 0);
        4: issue(1, a, $urandom, 5'($urandom), 0, 1, 1'($urandom), 1);
        5: issue(1, a, $urandom, 5'($urandom), 1, 0, 1'($urandom), 0);
        6: issue(1, a, $urandom, 5'($urandom), 1, 0, 1'($urandom), 1);
        default: issue(1, a, $urandom, 5'($urandom), 1, 1, 1'($urandom), 1'($urandom));
      endcase
    end
    wait_idle();
    repeat (3) @(negedge clk);
    junk_en = 1'b0;
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    chk("align_pulses", seen_align, exp_align);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
